// File: rtl/barrel_shifter_seq_logical_if.sv
// Operand/result bundle for the sequential logical shifter.
interface barrel_shifter_seq_logical_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 2
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   sh_amt;
    logic             dir;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start,
        output din,
        output sh_amt,
        output dir,
        input  busy,
        input  done,
        input  dout
    );

    // Shifter side.
    modport slave (
        input  start,
        input  din,
        input  sh_amt,
        input  dir,
        output busy,
        output done,
        output dout
    );
endinterface

// File: rtl/barrel_shifter_seq_logical.sv
// Multi-cycle logical shifter: one bit position per clock, zero fill,
// start/busy handshake in, single-cycle done pulse out.
module barrel_shifter_seq_logical #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    barrel_shifter_seq_logical_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   cnt;
    logic             dir_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] dout_r;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.dout = dout_r;

    // Control FSM and datapath: accept in IDLE, shift until count reaches zero, then publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data   <= '0;
            cnt    <= '0;
            dir_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dout_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data   <= bus.din;
                        cnt    <= bus.sh_amt;
                        dir_r  <= bus.dir;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        if (dir_r) begin
                            data <= {1'b0, data[WIDTH-1:1]};
                        end else begin
                            data <= {data[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt - SHW'(1);
                    end else begin
                        dout_r <= data;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shifter_seq_logical.sv
// Scoreboard bench for the sequential logical shifter (4-bit and 8-bit instances).
module tb_barrel_shifter_seq_logical;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [7:0] din;
        int         amt;
        logic       dir;
        logic [7:0] exp;
        int         w;
        int         cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    barrel_shifter_seq_logical_if #(.WIDTH(4), .SHW(2)) b4 ();
    barrel_shifter_seq_logical_if #(.WIDTH(8), .SHW(3)) b8 ();

    barrel_shifter_seq_logical #(.WIDTH(4), .SHW(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    barrel_shifter_seq_logical #(.WIDTH(8), .SHW(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational reference: zero-filled logical shift truncated to w bits.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt,
                                             input logic dr, input int w);
        int m;
        int r;
        m = (1 << w) - 1;
        r = dr ? (int'(d) >> amt) : (int'(d) << amt);
        return 8'(r & m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_line(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // 4-bit monitor: pop on each done, check value, model agreement and latency.
    logic prev_done4;
    always @(negedge clk) begin
        if (b4.done) begin
            if (q4.size() == 0) begin
                fail_line("unexpected done w4");
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dout w4", 32'(b4.dout), 32'(e.exp[3:0]));
                check("model w4", 32'(b4.dout), 32'(ref_shift(e.din, e.amt, e.dir, 4)));
                check("latency w4", 32'(cyc), 32'(e.cyc + e.amt + 1));
            end
            if (prev_done4) fail_line("done pulse longer than one cycle w4");
        end
        prev_done4 <= b4.done;
    end

    // 8-bit monitor.
    always @(negedge clk) begin
        if (b8.done) begin
            if (q8.size() == 0) begin
                fail_line("unexpected done w8");
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("dout w8", 32'(b8.dout), 32'(e.exp));
                check("model w8", 32'(b8.dout), 32'(ref_shift(e.din, e.amt, e.dir, 8)));
                check("latency w8", 32'(cyc), 32'(e.cyc + e.amt + 1));
            end
        end
    end

    task automatic issue4(input logic [3:0] d, input int amt, input logic dr,
                          input logic [3:0] exp, output logic in_done);
        int t;
        t = 0;
        @(negedge clk);
        while (b4.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (b4.busy) fail_line("timeout waiting for idle w4");
        in_done   = b4.done;
        b4.start  = 1'b1;
        b4.din    = d;
        b4.sh_amt = 2'(amt);
        b4.dir    = dr;
        @(posedge clk);
        #1;
        q4.push_back('{din: 8'(d), amt: amt, dir: dr, exp: 8'(exp), w: 4, cyc: cyc});
        b4.start  = 1'b0;
        b4.din    = ~d;
        b4.dir    = ~dr;
    endtask

    task automatic issue8(input logic [7:0] d, input int amt, input logic dr,
                          input logic [7:0] exp);
        int t;
        t = 0;
        @(negedge clk);
        while (b8.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (b8.busy) fail_line("timeout waiting for idle w8");
        b8.start  = 1'b1;
        b8.din    = d;
        b8.sh_amt = 3'(amt);
        b8.dir    = dr;
        @(posedge clk);
        #1;
        q8.push_back('{din: d, amt: amt, dir: dr, exp: exp, w: 8, cyc: cyc});
        b8.start  = 1'b0;
        b8.din    = ~d;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q4.size() != 0 || q8.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q4.size() != 0 || q8.size() != 0) fail_line(name);
        @(negedge clk);
    endtask

    logic       acc;
    logic [3:0] left_exp  [4];
    logic [3:0] right_exp [4];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        prev_done4 = 1'b0;
        rst_n      = 1'b0;
        b4.start = 1'b0; b4.din = '0; b4.sh_amt = '0; b4.dir = 1'b0;
        b8.start = 1'b0; b8.din = '0; b8.sh_amt = '0; b8.dir = 1'b0;
        left_exp  = '{4'b1011, 4'b0110, 4'b1100, 4'b1000};
        right_exp = '{4'b1011, 4'b0101, 4'b0010, 4'b0001};

        #3;
        check("reset busy w4", 32'(b4.busy), 32'd0);
        check("reset done w4", 32'(b4.done), 32'd0);
        check("reset dout w4", 32'(b4.dout), 32'd0);
        check("reset busy w8", 32'(b8.busy), 32'd0);
        check("reset dout w8", 32'(b8.dout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Left and right sweeps over all shift amounts.
        for (int i = 0; i < 4; i++) issue4(4'b1011, i, 1'b0, left_exp[i], acc);
        drain("drain left sweep");
        for (int i = 0; i < 4; i++) issue4(4'b1011, i, 1'b1, right_exp[i], acc);
        drain("drain right sweep");

        // Start while busy is ignored.
        issue4(4'b1011, 3, 1'b0, 4'b1000, acc);
        @(negedge clk);
        b4.start = 1'b1; b4.din = 4'b0001; b4.sh_amt = 2'd0; b4.dir = 1'b1;
        check("busy during stray start", 32'(b4.busy), 32'd1);
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        check("busy after stray start", 32'(b4.busy), 32'd1);
        drain("drain ignored start");

        // Back-to-back: second op accepted in the done cycle of the first.
        issue4(4'b1011, 1, 1'b1, 4'b0101, acc);
        issue4(4'b1011, 2, 1'b0, 4'b1100, acc);
        check("accepted in done cycle", 32'(acc), 32'd1);
        drain("drain back-to-back");

        // Asynchronous reset mid-operation.
        issue4(4'b1011, 3, 1'b0, 4'b1000, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-op reset busy", 32'(b4.busy), 32'd0);
        check("mid-op reset done", 32'(b4.done), 32'd0);
        check("mid-op reset dout", 32'(b4.dout), 32'd0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue4(4'b0110, 1, 1'b1, 4'b0011, acc);
        drain("drain after reset");

        // 8-bit instance.
        issue8(8'hB5, 7, 1'b0, 8'h80);
        issue8(8'hB5, 4, 1'b1, 8'h0B);
        issue8(8'h81, 7, 1'b1, 8'h01);
        issue8(8'hFF, 0, 1'b0, 8'hFF);
        issue8(8'h3C, 2, 1'b0, 8'hF0);
        drain("drain w8");

        check("dout holds w4", 32'(b4.dout), 32'h3);
        check("dout holds w8", 32'(b8.dout), 32'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
